// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag indices and width for the execute-stage ALU
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_PASSB = 4'b1110;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/function inputs and registered result/flag outputs
interface alu_if;
  import alu_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       f;
  logic [WIDTH-1:0] y;
  logic [3:0]       zero;

  modport master (output a, output b, output f, input y, input zero);
  modport slave  (input a, input b, input f, output y, output zero);

endinterface

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared 32-bit adder computing a+b or a+~b+1
module alu_addsub
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  // Subtraction reuses the adder by inverting b and injecting a carry-in.
  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];
  // Same-sign inputs to the adder whose sum changes sign: covers both
  // ADD and SUB since b_eff already carries the inversion.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered 32-bit ALU with Z/N/C/V flags
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic             is_sub;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [3:0]       flags;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       zero_q;

  assign is_sub = (bus.f == OP_SUB) || (bus.f == OP_SLT) || (bus.f == OP_SLTU);
  assign shamt  = bus.b[4:0];

  alu_addsub u_addsub (
    .a        (bus.a),
    .b        (bus.b),
    .sub      (is_sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  // Operation mux: result plus the carry/overflow that only arithmetic ops report.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (bus.f)
      OP_AND:   res = bus.a & bus.b;
      OP_OR:    res = bus.a | bus.b;
      OP_ADD: begin
        res   = sum;
        res_c = carry;
        res_v = overflow;
      end
      OP_XOR:   res = bus.a ^ bus.b;
      OP_ANDN:  res = bus.a & ~bus.b;
      OP_ORN:   res = bus.a | ~bus.b;
      OP_SUB: begin
        res   = sum;
        res_c = carry;
        res_v = overflow;
      end
      OP_SLT: begin
        res   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
        res_c = carry;
        res_v = overflow;
      end
      OP_NOR:   res = ~(bus.a | bus.b);
      OP_SLTU: begin
        res   = {{(WIDTH-1){1'b0}}, ~carry};
        res_c = carry;
        res_v = overflow;
      end
      OP_SLL:   res = bus.a << shamt;
      OP_SRL:   res = bus.a >> shamt;
      OP_SRA:   res = $unsigned($signed(bus.a) >>> shamt);
      OP_XNOR:  res = ~(bus.a ^ bus.b);
      OP_PASSB: res = bus.b;
      default:  res = '0;
    endcase
  end

  // Flag vector: Z and N always come from the final result.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[WIDTH-1];
    flags[FLAG_C] = res_c;
    flags[FLAG_V] = res_v;
  end

  // Output register; reset clears the result and leaves only Z set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      zero_q <= 4'b0001;
    end else begin
      y_q    <= res;
      zero_q <= flags;
    end
  end

  assign bus.y    = y_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for the registered ALU
module tb_alu;
  import alu_pkg::*;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;
  localparam logic [35:0] RST_EXP = {4'b0001, 32'h0000_0000};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [35:0] exp_q;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: {V,C,N,Z,y} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] f);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    logic [31:0] y = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (f)
      4'd0:  y = a & b;
      4'd1:  y = a | b;
      4'd2: begin
        y = a + b;
        c = (ua + ub) > 64'sd4294967295;
        v = (sa + sb > MAX_S) || (sa + sb < MIN_S);
      end
      4'd3:  y = a ^ b;
      4'd4:  y = a & ~b;
      4'd5:  y = a | ~b;
      4'd6, 4'd7, 4'd9: begin
        c = (ua >= ub);
        v = (sa - sb > MAX_S) || (sa - sb < MIN_S);
        if (f == 4'd6) y = a - b;
        else if (f == 4'd7) y = (sa < sb) ? 32'd1 : 32'd0;
        else y = (ua < ub) ? 32'd1 : 32'd0;
      end
      4'd8:  y = ~(a | b);
      4'd10: y = a << b[4:0];
      4'd11: y = a >> b[4:0];
      4'd12: y = $unsigned($signed(a) >>> b[4:0]);
      4'd13: y = ~(a ^ b);
      4'd14: y = b;
      default: y = '0;
    endcase
    return {v, c, y[31], (y == 32'h0), y};
  endfunction

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got y=%h flags=%b, want y=%h flags=%b",
               nm, act[31:0], act[35:32], req[31:0], req[35:32]);
    end
  endtask

  // Expected outputs track the inputs captured at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= RST_EXP;
    else        exp_q <= model(bus.a, bus.b, bus.f);
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) check("pipe", {bus.zero, bus.y}, exp_q);
  end

  task automatic vec(input string nm, input logic [3:0] op, input logic [31:0] va,
                     input logic [31:0] vb, input logic [31:0] ey, input logic [3:0] ez);
    @(negedge clk);
    bus.a = va;
    bus.b = vb;
    bus.f = op;
    @(posedge clk);
    #1;
    check(nm, {bus.zero, bus.y}, {ez, ey});
    check({nm, "_model"}, model(va, vb, op), {ez, ey});
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    bus.f = '0;
    @(posedge clk);
    #1;
    check("reset_state", {bus.zero, bus.y}, RST_EXP);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    vec("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 4'b1010);
    vec("sub_eq",   OP_SUB,  32'd5,         32'd5,          32'h0,         4'b0101);
    vec("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,         4'b0100);
    vec("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,         4'b0101);
    vec("sra",      OP_SRA,  32'h8000_0000, 32'h0000_0024,  32'hF800_0000, 4'b0010);
    vec("srl",      OP_SRL,  32'h8000_0000, 32'h0000_0024,  32'h0800_0000, 4'b0000);
    vec("sll",      OP_SLL,  32'h8000_0000, 32'h0000_0024,  32'h0,         4'b0001);
    vec("sll_zero", OP_SLL,  32'h1234_5678, 32'hFFFF_FFE0,  32'h1234_5678, 4'b0000);
    vec("and",      OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'h00F0_00F0, 4'b0000);
    vec("nor",      OP_NOR,  32'h0,         32'h0,          32'hFFFF_FFFF, 4'b0010);
    vec("rsvd",     OP_RSVD, 32'h5,         32'h7,          32'h0,         4'b0001);
    vec("add_c",    OP_ADD,  32'hFFFF_FFFF, 32'h2,          32'h1,         4'b0100);

    // Asynchronous reset mid-stream with live inputs.
    @(negedge clk);
    bus.a = 32'h1111_1111;
    bus.b = 32'h2222_2222;
    bus.f = OP_ADD;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {bus.zero, bus.y}, RST_EXP);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vec("add_3_4",  OP_ADD,  32'd3,         32'd4,          32'd7,         4'b0000);

    // Back-to-back operations across every opcode.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.f = 4'(i);
      bus.a = $urandom;
      bus.b = (i % 2 == 0) ? $urandom : bus.a;
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
